// File: rtl/rgb2ycc.sv
// RGB to YCbCr/Y converter: 3-stage pipeline with a double-buffered coefficient bank swapped on vsync rise.
// Optional macro RGB2YCC_ROUND_EN adds round-half-up before the fractional shift (default: floor).
module rgb2ycc #(
   parameter int COLORDEPTH = 8,
   parameter int COEFW      = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [3*COLORDEPTH-1:0]   rgb_i,
   input  logic                      dv_i,
   input  logic                      hs_i,
   input  logic                      vs_i,
   input  logic                      ycc_en_i,
   input  logic                      coef_we_i,
   input  logic [3:0]                coef_addr_i,
   input  logic [COEFW-1:0]          coef_data_i,
   output logic [COLORDEPTH-1:0]     y_o,
   output logic [COLORDEPTH-1:0]     cb_o,
   output logic [COLORDEPTH-1:0]     cr_o,
   output logic                      dv_o,
   output logic                      hs_o,
   output logic                      vs_o,
   output logic                      line_end_o,
   output logic                      coef_pend_o
);

   localparam int FRAC = COEFW - 2;
   localparam int PW   = COLORDEPTH + 1 + COEFW;
   localparam int SW   = PW + 2;
   localparam int OFF  = 2 ** (COLORDEPTH - 1);
   localparam int MAXV = 2 ** COLORDEPTH - 1;

   typedef logic signed [COEFW-1:0] coef_t;
   typedef logic signed [PW-1:0]    prod_t;
   typedef logic signed [SW-1:0]    sum_t;

   coef_t                  shadow [9];
   coef_t                  active [9];
   logic                   active_ycc;
   logic                   vs_prev;
   logic                   vs_rise;
   logic                   coef_acc;

   logic [COLORDEPTH-1:0]  px1 [3];
   logic                   dv1, hs1, vs1;
   prod_t                  prod [9];
   logic                   dv2, hs2, vs2, m2;

   function automatic coef_t coef_default(input int unsigned idx);
      case (idx)
         0: return coef_t'(306);
         1: return coef_t'(601);
         2: return coef_t'(117);
         3: return coef_t'(-173);
         4: return coef_t'(-339);
         5: return coef_t'(512);
         6: return coef_t'(512);
         7: return coef_t'(-429);
         default: return coef_t'(-83);
      endcase
   endfunction

   function automatic prod_t mul(input logic [COLORDEPTH-1:0] c, input coef_t k);
      prod_t a, b;
      a = prod_t'($signed({1'b0, c}));
      b = prod_t'(k);
      return a * b;
   endfunction

   function automatic logic [COLORDEPTH-1:0] sat_comp(input prod_t p0, input prod_t p1,
                                                      input prod_t p2, input logic add_off);
      sum_t s;
      s = sum_t'(p0) + sum_t'(p1) + sum_t'(p2);
`ifdef RGB2YCC_ROUND_EN
      s = s + sum_t'(2 ** (FRAC - 1));
`endif
      s = s >>> FRAC;
      if (add_off) s = s + sum_t'(OFF);
      if (s < 0) return '0;
      if (s > sum_t'(MAXV)) return '1;
      return s[COLORDEPTH-1:0];
   endfunction

   assign vs_rise  = vs_i & ~vs_prev;
   assign coef_acc = coef_we_i && (coef_addr_i <= 4'd8);

   // The swap copies the shadow contents as they stood before this edge, so a
   // coincident write lands in the shadow only and stays pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 9; i++) begin
            shadow[i] <= coef_default(i);
            active[i] <= coef_default(i);
         end
         active_ycc  <= 1'b1;
         vs_prev     <= 1'b0;
         coef_pend_o <= 1'b0;
      end else begin
         vs_prev <= vs_i;
         if (vs_rise) begin
            for (int unsigned i = 0; i < 9; i++) active[i] <= shadow[i];
            active_ycc <= ycc_en_i;
         end
         if (coef_acc) shadow[coef_addr_i] <= coef_data_i;
         if (coef_acc)     coef_pend_o <= 1'b1;
         else if (vs_rise) coef_pend_o <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 3; i++) px1[i] <= '0;
         dv1 <= 1'b0;
         hs1 <= 1'b0;
         vs1 <= 1'b0;
      end else begin
         px1[0] <= dv_i ? rgb_i[3*COLORDEPTH-1:2*COLORDEPTH] : '0;
         px1[1] <= dv_i ? rgb_i[2*COLORDEPTH-1:COLORDEPTH]   : '0;
         px1[2] <= dv_i ? rgb_i[COLORDEPTH-1:0]              : '0;
         dv1    <= dv_i;
         hs1    <= hs_i;
         vs1    <= vs_i;
      end
   end

   // Chroma products freeze while the active mode is Y-only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < 9; k++) prod[k] <= '0;
         dv2 <= 1'b0;
         hs2 <= 1'b0;
         vs2 <= 1'b0;
         m2  <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < 3; k++) prod[k] <= mul(px1[k], active[k]);
         if (active_ycc) begin
            for (int unsigned k = 3; k < 9; k++) prod[k] <= mul(px1[k % 3], active[k]);
         end
         dv2 <= dv1;
         hs2 <= hs1;
         vs2 <= vs1;
         m2  <= active_ycc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y_o        <= '0;
         cb_o       <= '0;
         cr_o       <= '0;
         dv_o       <= 1'b0;
         hs_o       <= 1'b0;
         vs_o       <= 1'b0;
         line_end_o <= 1'b0;
      end else begin
         y_o  <= dv2 ? sat_comp(prod[0], prod[1], prod[2], 1'b0) : '0;
         cb_o <= !dv2 ? '0 : (m2 ? sat_comp(prod[3], prod[4], prod[5], 1'b1) : COLORDEPTH'(OFF));
         cr_o <= !dv2 ? '0 : (m2 ? sat_comp(prod[6], prod[7], prod[8], 1'b1) : COLORDEPTH'(OFF));
         dv_o       <= dv2;
         hs_o       <= hs2;
         vs_o       <= vs2;
         line_end_o <= dv_o & ~dv2;
      end
   end

endmodule
